bank_timing_tracker: RTL and testbench
======================================

Name: bank_timing_tracker

Overview:
Parametrised per-bank and inter-bank DRAM timing tracker for the command scheduler. It sits between the scheduler FSM and the command bus. For every bank it tracks ACT->RD/WR, earliest-PRE and earliest-ACT windows. Globally it tracks tRRD, tFAW and tRFC. It exports per-bank "command permitted" vectors and flags any issued command that breaks timing.

Parameters:
NUM_BANKS, 8, number of banks tracked
BA_BITS, 3, bank address width (clog2 NUM_BANKS)
CNT_W, 8, width of every timing counter
T_RCD, 11, ACT to RD/WR (cycles)
T_RP, 11, PRE to ACT
T_RAS, 28, ACT to PRE
T_RTP, 6, RD to PRE
T_WR, 12, write recovery
T_WL, 9, total write latency
T_RRD, 5, ACT to ACT, different banks
T_FAW, 24, four-activate window
T_RFC, 88, REF to any ACT/REF

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command issued this cycle
cmd_type  in  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF (all-bank); 6, 7 treated as NOP
cmd_bank  in  BA_BITS  target bank; ignored for REF
auto_pre  in  1  RD/WR carries auto-precharge
bl4  in  1  1 = burst 4 (2 data cycles), 0 = BL8/on-the-fly (4 data cycles)
act_ok  out  NUM_BANKS  ACT legal to bank i this cycle
rw_ok  out  NUM_BANKS  RD/WR legal to bank i
pre_ok  out  NUM_BANKS  PRE legal to bank i
ref_ok  out  1  REF legal
bank_open  out  NUM_BANKS  bank i has an open row
viol  out  1  one-cycle pulse: previous-cycle command was illegal
viol_code  out  3  cmd_type of the violating command; holds until next viol

Behaviour:
Reset:
- All counters 0, bank_open 0, viol 0, viol_code 0.
- Outputs derive from state, so after reset act_ok is all 1s, ref_ok 1, rw_ok 0, pre_ok all 1s.

Counters:
- All counters saturating down-counters, decrement by 1 per cycle, floor 0.
- "Load" means the counter equals the load value on the cycle after issue. A load of N-1 therefore permits the next command exactly N cycles after issue.
- "maxload X" = counter <= max(decremented current, X). A window is never shortened.

Per-bank state: cnt_rcd, cnt_pre, cnt_act.

Global state:
- cnt_rrd.
- cnt_rfc.
- Four faw slots faw[0..3].

Command effects (cmd_valid=1, target bank b; non-target banks only decrement):
- ACT:
  - bank_open[b]=1.
  - cnt_rcd[b] load T_RCD-1.
  - cnt_pre[b] maxload T_RAS-1.
  - cnt_act[b] maxload T_RAS+T_RP-1 (tRC).
  - cnt_rrd load T_RRD-1.
  - Lowest-index faw slot equal to 0 loads T_FAW-1.
- RD, no AP: cnt_pre[b] maxload T_RTP-1.
- RD with AP:
  - bank_open[b]=0 at issue.
  - cnt_act[b] maxload T_RTP+T_RP-1.
- WR, no AP: cnt_pre[b] maxload T_WL+D+T_WR-1, where D = bl4 ? 2 : 4.
- WR with AP:
  - bank_open[b]=0.
  - cnt_act[b] maxload T_WL+D+T_WR+T_RP-1.
- PRE on an open bank:
  - bank_open[b]=0.
  - cnt_act[b] maxload T_RP-1.
- PRE on a closed bank: no state change, not a violation.
- REF: cnt_rfc load T_RFC-1.

Permission equations (combinational from registered state):
- act_ok[i] = !bank_open[i] & cnt_act[i]==0 & cnt_rrd==0 & any faw==0 & cnt_rfc==0.
- rw_ok[i] = bank_open[i] & cnt_rcd[i]==0.
- pre_ok[i] = !bank_open[i] | cnt_pre[i]==0.
- ref_ok = bank_open==0 & all cnt_act==0 & cnt_rfc==0.

Violations:
- A command whose permission bit is 0 in its issue cycle gives viol=1 on the next cycle.
- viol_code = cmd_type of that command.
- The command's state effects are still applied, so the tracker follows the real device.

Timing and boundaries:
- One command per cycle, so there are no intra-cycle conflicts.
- Loads take priority over decrement on the same counter.
- Counters never wrap. Parameter sums must fit CNT_W; this is checked by an elaboration-time assertion.
- rst_n low mid-operation clears everything on the next edge regardless of cmd_valid.

Test Plan:
- ACT bank 2 at t0 -> rw_ok[2]=0 for t0+1..t0+10 and 1 at t0+11. pre_ok[2]=1 first at t0+28. act_ok[3]=0 until t0+5.
- ACT bank 0 at t0, then WR BL8 bank 0 at t0+11 -> pre_ok[0] first 1 at t0+11+25=t0+36. With bl4=1 it is t0+34.
- RD with AP bank 1 at t0+11, after ACT at t0 -> bank_open[1]=0 at t0+12. act_ok[1] first 1 at max(t0+39 tRC, t0+28) = t0+39.
- ACTs to banks 0..3 at t0, t0+5, t0+10, t0+15 -> act_ok[4]=0 at t0+20. act_ok[4] becomes 1 at t0+24 when the faw slot frees.
- REF at t0 with all banks closed -> act_ok all 0 until t0+88 and ref_ok=0 until t0+88. A RD to a closed bank at t0+1 gives viol=1 and viol_code=2 at t0+2.
- Pulse rst_n low for one cycle mid-tRAS -> all counters 0, bank_open=0, act_ok all 1s on the next cycle.

Source files
------------

// File: rtl/bank_timing_tracker.sv
// bank_timing_tracker: per-bank and inter-bank DRAM timing windows, command permits and violation flagging.
module bank_timing_tracker #(
  parameter int NUM_BANKS = 8,
  parameter int BA_BITS   = 3,
  parameter int CNT_W     = 8,
  parameter int T_RCD     = 11,
  parameter int T_RP      = 11,
  parameter int T_RAS     = 28,
  parameter int T_RTP     = 6,
  parameter int T_WR      = 12,
  parameter int T_WL      = 9,
  parameter int T_RRD     = 5,
  parameter int T_FAW     = 24,
  parameter int T_RFC     = 88
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  input  logic [2:0]           cmd_type,
  input  logic [BA_BITS-1:0]   cmd_bank,
  input  logic                 auto_pre,
  input  logic                 bl4,
  output logic [NUM_BANKS-1:0] act_ok,
  output logic [NUM_BANKS-1:0] rw_ok,
  output logic [NUM_BANKS-1:0] pre_ok,
  output logic                 ref_ok,
  output logic [NUM_BANKS-1:0] bank_open,
  output logic                 viol,
  output logic [2:0]           viol_code
);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam logic [2:0] C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3, C_PRE = 3'd4, C_REF = 3'd5;
  localparam cnt_t L_RCD  = cnt_t'(T_RCD - 1);
  localparam cnt_t L_RAS  = cnt_t'(T_RAS - 1);
  localparam cnt_t L_RC   = cnt_t'(T_RAS + T_RP - 1);
  localparam cnt_t L_RTP  = cnt_t'(T_RTP - 1);
  localparam cnt_t L_RTPP = cnt_t'(T_RTP + T_RP - 1);
  localparam cnt_t L_WR8  = cnt_t'(T_WL + 4 + T_WR - 1);
  localparam cnt_t L_WR4  = cnt_t'(T_WL + 2 + T_WR - 1);
  localparam cnt_t L_WRP8 = cnt_t'(T_WL + 4 + T_WR + T_RP - 1);
  localparam cnt_t L_WRP4 = cnt_t'(T_WL + 2 + T_WR + T_RP - 1);
  localparam cnt_t L_RP   = cnt_t'(T_RP - 1);
  localparam cnt_t L_RRD  = cnt_t'(T_RRD - 1);
  localparam cnt_t L_FAW  = cnt_t'(T_FAW - 1);
  localparam cnt_t L_RFC  = cnt_t'(T_RFC - 1);
  if (T_WL + 4 + T_WR + T_RP > 2**CNT_W || T_RAS + T_RP > 2**CNT_W || T_RFC > 2**CNT_W ||
      T_FAW > 2**CNT_W || T_RCD > 2**CNT_W || T_RRD > 2**CNT_W) begin : g_cnt_w_check
    $error("bank_timing_tracker: timing parameters overflow CNT_W");
  end
  function automatic cnt_t dec(input cnt_t x);
    return (x == '0) ? x : x - cnt_t'(1);
  endfunction
  function automatic cnt_t mx(input cnt_t a, input cnt_t b);
    return (a > b) ? a : b;
  endfunction
  cnt_t [NUM_BANKS-1:0] rcd_q, rcd_d, pre_q, pre_d, act_q, act_d;
  cnt_t [3:0]           faw_q, faw_d;
  cnt_t                 rrd_q, rrd_d, rfc_q, rfc_d;
  logic [NUM_BANKS-1:0] open_q, open_d;
  logic                 viol_q, viol_d, faw_free, act_idle, ok, taken;
  logic [2:0]           code_q, code_d;
  always_comb begin
    faw_free = 1'b0;
    act_idle = 1'b1;
    for (int k = 0; k < 4; k++) faw_free = faw_free | (faw_q[k] == '0);
    for (int i = 0; i < NUM_BANKS; i++) begin
      act_ok[i] = !open_q[i] && act_q[i] == '0 && rrd_q == '0 && faw_free && rfc_q == '0;
      rw_ok[i]  = open_q[i] && rcd_q[i] == '0;
      pre_ok[i] = !open_q[i] || pre_q[i] == '0;
      act_idle  = act_idle && act_q[i] == '0;
    end
    ref_ok = open_q == '0 && act_idle && rfc_q == '0;
  end
  // Violating commands still update state so the model tracks what the device actually saw.
  always_comb begin
    open_d = open_q;
    rrd_d  = dec(rrd_q);
    rfc_d  = dec(rfc_q);
    taken  = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      rcd_d[i] = dec(rcd_q[i]);
      pre_d[i] = dec(pre_q[i]);
      act_d[i] = dec(act_q[i]);
    end
    for (int k = 0; k < 4; k++) faw_d[k] = dec(faw_q[k]);
    if (cmd_valid && cmd_type == C_ACT) begin
      open_d[cmd_bank] = 1'b1;
      rcd_d[cmd_bank]  = L_RCD;
      pre_d[cmd_bank]  = mx(pre_d[cmd_bank], L_RAS);
      act_d[cmd_bank]  = mx(act_d[cmd_bank], L_RC);
      rrd_d            = L_RRD;
      for (int k = 0; k < 4; k++)
        if (!taken && faw_q[k] == '0) begin
          faw_d[k] = L_FAW;
          taken    = 1'b1;
        end
    end
    if (cmd_valid && cmd_type == C_RD && auto_pre) begin
      open_d[cmd_bank] = 1'b0;
      act_d[cmd_bank]  = mx(act_d[cmd_bank], L_RTPP);
    end
    if (cmd_valid && cmd_type == C_RD && !auto_pre) pre_d[cmd_bank] = mx(pre_d[cmd_bank], L_RTP);
    if (cmd_valid && cmd_type == C_WR && auto_pre) begin
      open_d[cmd_bank] = 1'b0;
      act_d[cmd_bank]  = mx(act_d[cmd_bank], bl4 ? L_WRP4 : L_WRP8);
    end
    if (cmd_valid && cmd_type == C_WR && !auto_pre) pre_d[cmd_bank] = mx(pre_d[cmd_bank], bl4 ? L_WR4 : L_WR8);
    if (cmd_valid && cmd_type == C_PRE && open_q[cmd_bank]) begin
      open_d[cmd_bank] = 1'b0;
      act_d[cmd_bank]  = mx(act_d[cmd_bank], L_RP);
    end
    if (cmd_valid && cmd_type == C_REF) rfc_d = L_RFC;
    ok = (cmd_type == C_ACT) ? act_ok[cmd_bank] :
         (cmd_type == C_RD || cmd_type == C_WR) ? rw_ok[cmd_bank] :
         (cmd_type == C_PRE) ? pre_ok[cmd_bank] :
         (cmd_type == C_REF) ? ref_ok : 1'b1;
    viol_d = cmd_valid && !ok;
    code_d = viol_d ? cmd_type : code_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcd_q  <= '0;
      pre_q  <= '0;
      act_q  <= '0;
      faw_q  <= '0;
      rrd_q  <= '0;
      rfc_q  <= '0;
      open_q <= '0;
      viol_q <= 1'b0;
      code_q <= '0;
    end else begin
      rcd_q  <= rcd_d;
      pre_q  <= pre_d;
      act_q  <= act_d;
      faw_q  <= faw_d;
      rrd_q  <= rrd_d;
      rfc_q  <= rfc_d;
      open_q <= open_d;
      viol_q <= viol_d;
      code_q <= code_d;
    end
  end
  assign bank_open = open_q;
  assign viol      = viol_q;
  assign viol_code = code_q;
endmodule

// File: tb/tb_bank_timing_tracker.sv
// tb_bank_timing_tracker: table-driven command vectors with a viol scoreboard, plus timed window sequences.
module tb_bank_timing_tracker;
  logic       clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, auto_pre = 1'b0, bl4 = 1'b0;
  logic [2:0] cmd_type = '0, cmd_bank = '0;
  logic [7:0] act_ok, rw_ok, pre_ok, bank_open;
  logic       ref_ok, viol;
  logic [2:0] viol_code;
  int checks = 0, errors = 0;
  logic [3:0] exp_q[$];

  bank_timing_tracker dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_bank(cmd_bank),
    .auto_pre(auto_pre), .bl4(bl4), .act_ok(act_ok), .rw_ok(rw_ok), .pre_ok(pre_ok),
    .ref_ok(ref_ok), .bank_open(bank_open), .viol(viol), .viol_code(viol_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idle;
    logic       vld;
    logic [2:0] typ;
    logic [2:0] bank;
    logic       ap;
    logic       b4;
    logic       ev;
    logic [2:0] ec;
    logic [7:0] eo;
  } vec_t;
  vec_t tv[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue(input logic vld, input logic [2:0] t, input logic [2:0] b, input logic ap,
                       input logic b4, input logic ev, input logic [2:0] ec);
    logic [3:0] e;
    cmd_valid = vld;
    cmd_type  = t;
    cmd_bank  = b;
    auto_pre  = ap;
    bl4       = b4;
    exp_q.push_back({ev, ec});
    tick();
    cmd_valid = 1'b0;
    auto_pre  = 1'b0;
    bl4       = 1'b0;
    e = exp_q.pop_front();
    chk("viol", 32'(viol), 32'(e[3]));
    chk("viol_code", 32'(viol_code), 32'(e[2:0]));
  endtask

  task automatic wr_seq(input logic b4, input int first);
    do_reset();
    issue(1, 3'd1, 3'd0, 0, 0, 0, 3'd0);
    idle(10);
    issue(1, 3'd3, 3'd0, 0, b4, 0, 3'd0);
    for (int n = 12; n <= first + 1; n++) begin
      chk(b4 ? "pre_ok0_wr_bl4" : "pre_ok0_wr_bl8", 32'(pre_ok[0]), 32'(n >= first));
      tick();
    end
  endtask

  initial begin
    tv[0]  = '{0,   1, 3'd1, 3'd5, 0, 0, 0, 3'd0, 8'h20};
    tv[1]  = '{0,   1, 3'd2, 3'd5, 0, 0, 1, 3'd2, 8'h20};
    tv[2]  = '{0,   1, 3'd1, 3'd6, 0, 0, 1, 3'd1, 8'h60};
    tv[3]  = '{0,   1, 3'd4, 3'd5, 0, 0, 1, 3'd4, 8'h40};
    tv[4]  = '{0,   1, 3'd4, 3'd2, 0, 0, 0, 3'd4, 8'h40};
    tv[5]  = '{20,  1, 3'd3, 3'd6, 0, 0, 0, 3'd4, 8'h40};
    tv[6]  = '{0,   1, 3'd2, 3'd6, 1, 0, 0, 3'd4, 8'h00};
    tv[7]  = '{0,   1, 3'd5, 3'd0, 0, 0, 1, 3'd5, 8'h00};
    tv[8]  = '{0,   1, 3'd6, 3'd3, 0, 0, 0, 3'd5, 8'h00};
    tv[9]  = '{100, 1, 3'd1, 3'd0, 0, 0, 0, 3'd5, 8'h01};
    tv[10] = '{0,   0, 3'd1, 3'd0, 0, 0, 0, 3'd5, 8'h01};

    tick();
    do_reset();
    chk("rst_act_ok", 32'(act_ok), 32'h ff);
    chk("rst_rw_ok", 32'(rw_ok), 32'h0);
    chk("rst_pre_ok", 32'(pre_ok), 32'hff);
    chk("rst_ref_ok", 32'(ref_ok), 32'h1);
    chk("rst_bank_open", 32'(bank_open), 32'h0);
    chk("rst_viol", 32'(viol), 32'h0);
    chk("rst_viol_code", 32'(viol_code), 32'h0);

    for (int v = 0; v < 11; v++) begin
      idle(tv[v].idle);
      issue(tv[v].vld, tv[v].typ, tv[v].bank, tv[v].ap, tv[v].b4, tv[v].ev, tv[v].ec);
      chk("vec_bank_open", 32'(bank_open), 32'(tv[v].eo));
    end

    idle(5);
    rst_n = 1'b0;
    cmd_valid = 1'b1;
    cmd_type = 3'd1;
    cmd_bank = 3'd1;
    tick();
    rst_n = 1'b1;
    cmd_valid = 1'b0;
    chk("midrst_bank_open", 32'(bank_open), 32'h0);
    chk("midrst_act_ok", 32'(act_ok), 32'hff);
    chk("midrst_pre_ok", 32'(pre_ok), 32'hff);
    chk("midrst_ref_ok", 32'(ref_ok), 32'h1);
    chk("midrst_viol_code", 32'(viol_code), 32'h0);

    do_reset();
    issue(1, 3'd1, 3'd2, 0, 0, 0, 3'd0);
    for (int n = 1; n <= 28; n++) begin
      chk("rw_ok2_trcd", 32'(rw_ok[2]), 32'(n >= 11));
      chk("act_ok3_trrd", 32'(act_ok[3]), 32'(n >= 5));
      chk("pre_ok2_tras", 32'(pre_ok[2]), 32'(n >= 28));
      tick();
    end

    wr_seq(1'b0, 36);
    wr_seq(1'b1, 34);

    do_reset();
    issue(1, 3'd1, 3'd1, 0, 0, 0, 3'd0);
    idle(10);
    issue(1, 3'd2, 3'd1, 1, 0, 0, 3'd0);
    chk("rdap_bank_open1", 32'(bank_open[1]), 32'h0);
    for (int n = 12; n <= 40; n++) begin
      chk("act_ok1_trc", 32'(act_ok[1]), 32'(n >= 39));
      tick();
    end

    do_reset();
    for (int b = 0; b < 4; b++) begin
      issue(1, 3'd1, 3'(b), 0, 0, 0, 3'd0);
      if (b < 3) idle(4);
    end
    for (int n = 16; n <= 25; n++) begin
      chk("act_ok4_tfaw", 32'(act_ok[4]), 32'(n >= 24));
      tick();
    end

    do_reset();
    issue(1, 3'd5, 3'd0, 0, 0, 0, 3'd0);
    chk("ref_act_ok_t1", 32'(act_ok), 32'h0);
    issue(1, 3'd2, 3'd0, 0, 0, 1, 3'd2);
    for (int n = 2; n <= 89; n++) begin
      chk("act_ok_trfc", 32'(act_ok), (n >= 88) ? 32'hff : 32'h0);
      chk("ref_ok_trfc", 32'(ref_ok), 32'(n >= 88));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
